div_unit_arbiter: RTL and testbench
===================================

Name: div_unit_arbiter

Overview:
Sequences and shares the single iterative integer divider between the DIV-capable issue queues. Picks the oldest pending DIV candidate and drives each queue's do-not-issue-div input so only the granted queue may issue. Tracks the in-flight division, reserves the ALU writeback slot one cycle ahead, and aborts on branch mispredict flush.

Parameters:
NUM_PORTS, 2, number of issue queues that can hold DIV uops
DIV_LAT, 33, cycles from divider issue to result; minimum 2
SQN_W, 7, sequence number width
TAG_W, 7, destination tag width

Ports:
clk  in  1  clock
rst  in  1  reset (synchronous, active-high)
IN_req  in  NUM_PORTS  port i holds a ready DIV candidate this cycle
IN_reqSqN  in  NUM_PORTS x SQN_W  sqN of port i's oldest DIV candidate
IN_issue  in  NUM_PORTS  port i issued a DIV uop this cycle
IN_issueSqN  in  NUM_PORTS x SQN_W  sqN of the issued DIV uop
IN_issueTag  in  NUM_PORTS x TAG_W  tagDst of the issued DIV uop
IN_branchTaken  in  1  mispredict flush
IN_branchSqN  in  SQN_W  flush boundary; ops with sqN younger than this are killed
OUT_doNotIssueDiv  out  NUM_PORTS  per-queue DIV issue block
OUT_busy  out  1  divider occupied
OUT_wbReserve  out  1  one-cycle pulse; claims ALU writeback slot for next cycle
OUT_done  out  1  one-cycle pulse; result valid
OUT_tagDst  out  TAG_W  tag of completing division
OUT_sqN  out  SQN_W  sqN of completing division

Behaviour:
- Reset is clk and rst, synchronous, active-high. Reset state: IDLE, OUT_doNotIssueDiv all 1, OUT_busy 0, OUT_wbReserve 0, OUT_done 0, counter 0. OUT_tagDst and OUT_sqN are don't-care.
- Age compare: a is older than b iff $signed(a-b) < 0, computed in SQN_W bits so it wraps.
- All outputs are registered.
- State IDLE:
  - OUT_doNotIssueDiv is all 1.
  - If any IN_req is set and there is no flush, grant the port with the oldest IN_reqSqN. On equal sqN, the lowest index wins.
  - Register the grant and go to GRANT.
- State GRANT:
  - OUT_doNotIssueDiv is 0 only for the granted port.
  - If the granted port asserts IN_issue: latch its sqN and tag, set counter = DIV_LAT-1, set OUT_busy=1, go to BUSY. OUT_doNotIssueDiv returns to all 1 on the next cycle.
  - If the granted port does not assert IN_issue: return to IDLE and re-arbitrate. A granted port stalled by IN_stall simply misses its grant.
  - IN_issue on a non-granted port is a protocol error. Flag it with an assertion under DEBUG and otherwise ignore it.
- State BUSY:
  - OUT_doNotIssueDiv is all 1.
  - Counter decrements every cycle.
  - When counter==1, pulse OUT_wbReserve.
  - When counter==0, pulse OUT_done with the latched tag and sqN, clear OUT_busy, go to IDLE.
  - Timing: issue in cycle t gives OUT_wbReserve in cycle t+DIV_LAT-1 and OUT_done in cycle t+DIV_LAT.
- Back-to-back divisions: the earliest re-grant registers in the OUT_done cycle. The next issue is at t+DIV_LAT+1.
- Flush (IN_branchTaken) takes priority over all other transitions:
  - In BUSY, if the latched sqN is younger than IN_branchSqN: go to IDLE immediately. OUT_busy=0 next cycle, and no wbReserve or done is emitted. An older division continues unaffected.
  - In GRANT: return to IDLE. If the granted port's IN_issue is in the same cycle and its sqN is not younger, capture it normally.
  - In IDLE: no grant is made this cycle.
- Flush in the same cycle as counter==0: if the division is killed, suppress OUT_done.
- rst mid-division: abort with no output pulses.

Test Plan:
1. Single division, NUM_PORTS=2, DIV_LAT=33:
   - Stimulus: reset, then port0 req sqN=5 and issues when granted at cycle t (tag 0x12).
   - Required: wbReserve high only at t+32; done at t+33 with tag 0x12, sqN 5; busy high t+1..t+33.
2. Arbitration by age:
   - Stimulus: port0 sqN=10 and port1 sqN=8 request together.
   - Required: doNotIssueDiv = 2'b01 (port1 granted).
   - Wrap variant: sqN=126 vs 2 -> port0 granted.
3. Grant missed:
   - Stimulus: port1 granted but IN_issue stays 0.
   - Required: return to IDLE; doNotIssueDiv all 1 for one cycle, then re-grant.
4. Flush kills a younger division:
   - Stimulus: division sqN=20 busy; at counter 10 branch with sqN=15.
   - Required: busy=0 next cycle; no wbReserve or done ever emitted.
   - Same test with branch sqN=25: completes normally.
5. Flush at completion edge:
   - Stimulus: branch killing the op in its counter==0 cycle.
   - Required: OUT_done stays 0.
6. Back-to-back:
   - Stimulus: both ports continuously requesting.
   - Required: issues spaced exactly DIV_LAT+1 cycles apart; doNotIssueDiv never low for two ports at once.

Source files
------------

// File: rtl/div_unit_arbiter.sv
// Shares one iterative divider between the DIV-capable issue queues: oldest-first grant,
// in-flight tracking, one-cycle-early writeback reservation and mispredict abort.
module div_unit_arbiter #(
  parameter int NUM_PORTS = 2,
  parameter int DIV_LAT   = 33,
  parameter int SQN_W     = 7,
  parameter int TAG_W     = 7
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_PORTS-1:0]       IN_req,
  input  logic [NUM_PORTS*SQN_W-1:0] IN_reqSqN,
  input  logic [NUM_PORTS-1:0]       IN_issue,
  input  logic [NUM_PORTS*SQN_W-1:0] IN_issueSqN,
  input  logic [NUM_PORTS*TAG_W-1:0] IN_issueTag,
  input  logic                       IN_branchTaken,
  input  logic [SQN_W-1:0]           IN_branchSqN,
  output logic [NUM_PORTS-1:0]       OUT_doNotIssueDiv,
  output logic                       OUT_busy,
  output logic                       OUT_wbReserve,
  output logic                       OUT_done,
  output logic [TAG_W-1:0]           OUT_tagDst,
  output logic [SQN_W-1:0]           OUT_sqN
);

  localparam int IDX_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
  localparam int CNT_W = (DIV_LAT > 2) ? $clog2(DIV_LAT) : 1;

  typedef enum logic [1:0] {IDLE, GRANT, BUSY} state_t;

  state_t             state_r;
  logic [IDX_W-1:0]   gnt_idx_r;
  logic [CNT_W-1:0]   cnt_r;
  logic [SQN_W-1:0]   sqn_r;
  logic [TAG_W-1:0]   tag_r;

  logic               req_any_s;
  logic [IDX_W-1:0]   req_idx_s;
  logic [SQN_W-1:0]   best_sqn_s;
  logic               iss_s;
  logic [SQN_W-1:0]   iss_sqn_s;
  logic [TAG_W-1:0]   iss_tag_s;
  logic               kill_busy_s;
  logic               kill_iss_s;

  // a is older than b when the wrapped difference is negative
  function automatic logic is_older(input logic [SQN_W-1:0] a, input logic [SQN_W-1:0] b);
    logic [SQN_W-1:0] diff;
    diff = a - b;
    return diff[SQN_W-1];
  endfunction

  function automatic logic [NUM_PORTS-1:0] block_mask(input logic [IDX_W-1:0] idx);
    return ~(NUM_PORTS'(1) << idx);
  endfunction

  // Oldest-request selection; strict compare keeps the lowest index on ties
  always_comb begin
    req_any_s  = 1'b0;
    req_idx_s  = '0;
    best_sqn_s = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (IN_req[i] && (!req_any_s || is_older(IN_reqSqN[i*SQN_W +: SQN_W], best_sqn_s))) begin
        req_any_s  = 1'b1;
        req_idx_s  = IDX_W'(i);
        best_sqn_s = IN_reqSqN[i*SQN_W +: SQN_W];
      end else begin
        req_any_s  = req_any_s;
      end
    end
  end

  // Granted port's issue fields and flush kill decisions
  always_comb begin
    iss_s       = IN_issue[gnt_idx_r];
    iss_sqn_s   = IN_issueSqN[int'(gnt_idx_r)*SQN_W +: SQN_W];
    iss_tag_s   = IN_issueTag[int'(gnt_idx_r)*TAG_W +: TAG_W];
    kill_busy_s = IN_branchTaken && is_older(IN_branchSqN, sqn_r);
    kill_iss_s  = IN_branchTaken && is_older(IN_branchSqN, iss_sqn_s);
  end

  // Sequencer FSM with registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r           <= IDLE;
      gnt_idx_r         <= '0;
      cnt_r             <= '0;
      sqn_r             <= '0;
      tag_r             <= '0;
      OUT_doNotIssueDiv <= '1;
      OUT_busy          <= 1'b0;
      OUT_wbReserve     <= 1'b0;
      OUT_done          <= 1'b0;
      OUT_tagDst        <= '0;
      OUT_sqN           <= '0;
    end else begin
      OUT_doNotIssueDiv <= '1;
      OUT_wbReserve     <= 1'b0;
      OUT_done          <= 1'b0;
      case (state_r)
        IDLE: begin
          // busy is held through the done cycle and released here
          OUT_busy <= 1'b0;
          if (req_any_s && !IN_branchTaken) begin
            gnt_idx_r         <= req_idx_s;
            OUT_doNotIssueDiv <= block_mask(req_idx_s);
            state_r           <= GRANT;
          end
        end
        GRANT: begin
          if (iss_s && !kill_iss_s) begin
            sqn_r         <= iss_sqn_s;
            tag_r         <= iss_tag_s;
            // the issue cycle already counts as the first step of DIV_LAT-1
            cnt_r         <= CNT_W'(DIV_LAT - 2);
            OUT_busy      <= 1'b1;
            OUT_wbReserve <= (DIV_LAT == 32'd2);
            state_r       <= BUSY;
          end else begin
            state_r <= IDLE;
          end
        end
        BUSY: begin
          if (kill_busy_s) begin
            OUT_busy <= 1'b0;
            state_r  <= IDLE;
          end else if (cnt_r == '0) begin
            OUT_done   <= 1'b1;
            OUT_tagDst <= tag_r;
            OUT_sqN    <= sqn_r;
            state_r    <= IDLE;
          end else begin
            cnt_r         <= cnt_r - CNT_W'(1);
            OUT_wbReserve <= (cnt_r == CNT_W'(1));
          end
        end
        default: begin
          OUT_busy <= 1'b0;
          state_r  <= IDLE;
        end
      endcase
    end
  end

`ifdef DEBUG
  div_unit_arbiter_chk #(.NUM_PORTS(NUM_PORTS)) u_chk (
    .clk               (clk),
    .rst               (rst),
    .IN_issue          (IN_issue),
    .OUT_doNotIssueDiv (OUT_doNotIssueDiv)
  );
`endif

endmodule

`ifdef DEBUG
// Protocol checker: a queue must never issue a DIV while it is blocked.
module div_unit_arbiter_chk #(
  parameter int NUM_PORTS = 2
) (
  input logic                 clk,
  input logic                 rst,
  input logic [NUM_PORTS-1:0] IN_issue,
  input logic [NUM_PORTS-1:0] OUT_doNotIssueDiv
);
  // Issue from a non-granted port
  always_ff @(posedge clk) begin
    if (!rst) begin
      assert ((IN_issue & OUT_doNotIssueDiv) == '0)
        else $error("div issue on non-granted port %b", IN_issue);
    end
  end
endmodule
`endif

// File: tb/tb_div_unit_arbiter.sv
// Directed bench for div_unit_arbiter: arbitration table plus hand-written
// sequences for latency, missed grant, flush, and back-to-back operation.
module tb_div_unit_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  IN_req;
  logic [13:0] IN_reqSqN;
  logic [1:0]  IN_issue;
  logic [13:0] IN_issueSqN;
  logic [13:0] IN_issueTag;
  logic        IN_branchTaken;
  logic [6:0]  IN_branchSqN;
  logic [1:0]  OUT_doNotIssueDiv;
  logic        OUT_busy;
  logic        OUT_wbReserve;
  logic        OUT_done;
  logic [6:0]  OUT_tagDst;
  logic [6:0]  OUT_sqN;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  div_unit_arbiter #(.NUM_PORTS(2), .DIV_LAT(33), .SQN_W(7), .TAG_W(7)) dut (
    .clk               (clk),
    .rst               (rst),
    .IN_req            (IN_req),
    .IN_reqSqN         (IN_reqSqN),
    .IN_issue          (IN_issue),
    .IN_issueSqN       (IN_issueSqN),
    .IN_issueTag       (IN_issueTag),
    .IN_branchTaken    (IN_branchTaken),
    .IN_branchSqN      (IN_branchSqN),
    .OUT_doNotIssueDiv (OUT_doNotIssueDiv),
    .OUT_busy          (OUT_busy),
    .OUT_wbReserve     (OUT_wbReserve),
    .OUT_done          (OUT_done),
    .OUT_tagDst        (OUT_tagDst),
    .OUT_sqN           (OUT_sqN)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] req;
    logic [6:0] s0;
    logic [6:0] s1;
    logic       br;
    logic [1:0] exp_dni;
  } vec_t;

  vec_t vecs[8];

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic clear_in();
    IN_req         = 2'b00;
    IN_reqSqN      = 14'd0;
    IN_issue       = 2'b00;
    IN_issueSqN    = 14'd0;
    IN_issueTag    = 14'd0;
    IN_branchTaken = 1'b0;
    IN_branchSqN   = 7'd0;
  endtask

  task automatic do_reset();
    clear_in();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  // Request on one port, take the grant and issue; returns in cycle t+1
  task automatic start_div(input int port, input logic [6:0] sqn, input logic [6:0] tag);
    IN_req[port] = 1'b1;
    IN_reqSqN[port*7 +: 7] = sqn;
    tick();
    chk("start_grant", OUT_doNotIssueDiv, (port == 0) ? 2'b10 : 2'b01);
    IN_req = 2'b00;
    IN_issue[port] = 1'b1;
    IN_issueSqN[port*7 +: 7] = sqn;
    IN_issueTag[port*7 +: 7] = tag;
    tick();
    IN_issue = 2'b00;
    chk("start_busy", OUT_busy, 1'b1);
    chk("start_dni", OUT_doNotIssueDiv, 2'b11);
  endtask

  initial begin
    int seen;
    int last;
    int n_iss;
    int two_low;

    rst = 1'b1;
    clear_in();

    vecs[0] = '{2'b11, 7'd10,  7'd8,   1'b0, 2'b01};
    vecs[1] = '{2'b11, 7'd126, 7'd2,   1'b0, 2'b10};
    vecs[2] = '{2'b11, 7'd2,   7'd126, 1'b0, 2'b01};
    vecs[3] = '{2'b11, 7'd7,   7'd7,   1'b0, 2'b10};
    vecs[4] = '{2'b01, 7'd50,  7'd3,   1'b0, 2'b10};
    vecs[5] = '{2'b10, 7'd3,   7'd50,  1'b0, 2'b01};
    vecs[6] = '{2'b00, 7'd1,   7'd2,   1'b0, 2'b11};
    vecs[7] = '{2'b11, 7'd10,  7'd8,   1'b1, 2'b11};

    // reset state
    do_reset();
    chk("rst_dni", OUT_doNotIssueDiv, 2'b11);
    chk("rst_busy", OUT_busy, 1'b0);
    chk("rst_wb", OUT_wbReserve, 1'b0);
    chk("rst_done", OUT_done, 1'b0);

    // arbitration table
    for (int v = 0; v < 8; v++) begin
      do_reset();
      IN_req         = vecs[v].req;
      IN_reqSqN      = {vecs[v].s1, vecs[v].s0};
      IN_branchTaken = vecs[v].br;
      IN_branchSqN   = 7'd100;
      tick();
      chk($sformatf("arb_vec%0d", v), OUT_doNotIssueDiv, vecs[v].exp_dni);
      clear_in();
    end

    // single division latency
    do_reset();
    start_div(0, 7'd5, 7'h12);
    for (int k = 1; k <= 35; k++) begin
      if (k > 1) tick();
      chk($sformatf("lat_busy_t%0d", k), OUT_busy, (k <= 33) ? 1'b1 : 1'b0);
      chk($sformatf("lat_wb_t%0d", k), OUT_wbReserve, (k == 32) ? 1'b1 : 1'b0);
      chk($sformatf("lat_done_t%0d", k), OUT_done, (k == 33) ? 1'b1 : 1'b0);
      if (k == 33) begin
        chk("lat_tag", OUT_tagDst, 7'h12);
        chk("lat_sqn", OUT_sqN, 7'd5);
      end
    end

    // missed grant returns to IDLE then re-grants
    do_reset();
    IN_req = 2'b10;
    IN_reqSqN = {7'd9, 7'd0};
    tick();
    chk("miss_grant1", OUT_doNotIssueDiv, 2'b01);
    tick();
    chk("miss_idle", OUT_doNotIssueDiv, 2'b11);
    tick();
    chk("miss_grant2", OUT_doNotIssueDiv, 2'b01);
    clear_in();

    // flush kills a younger division at counter 10
    do_reset();
    start_div(0, 7'd20, 7'h33);
    for (int k = 0; k < 21; k++) tick();
    IN_branchTaken = 1'b1;
    IN_branchSqN   = 7'd15;
    tick();
    clear_in();
    chk("kill_busy", OUT_busy, 1'b0);
    seen = 0;
    for (int k = 0; k < 15; k++) begin
      if (OUT_wbReserve || OUT_done) seen++;
      tick();
    end
    chk("kill_no_pulse", seen, 0);

    // flush with older branch leaves the division alone
    do_reset();
    start_div(0, 7'd20, 7'h34);
    for (int k = 0; k < 21; k++) tick();
    IN_branchTaken = 1'b1;
    IN_branchSqN   = 7'd25;
    tick();
    clear_in();
    chk("keep_busy", OUT_busy, 1'b1);
    for (int k = 0; k < 9; k++) tick();
    chk("keep_wb", OUT_wbReserve, 1'b1);
    tick();
    chk("keep_done", OUT_done, 1'b1);
    chk("keep_tag", OUT_tagDst, 7'h34);
    chk("keep_sqn", OUT_sqN, 7'd20);

    // flush in the last counting cycle suppresses done
    do_reset();
    start_div(1, 7'd60, 7'h55);
    for (int k = 0; k < 31; k++) tick();
    chk("edge_wb", OUT_wbReserve, 1'b1);
    IN_branchTaken = 1'b1;
    IN_branchSqN   = 7'd50;
    tick();
    clear_in();
    chk("edge_busy", OUT_busy, 1'b0);
    seen = 0;
    for (int k = 0; k < 4; k++) begin
      if (OUT_done) seen++;
      tick();
    end
    chk("edge_no_done", seen, 0);

    // flush in the grant cycle: younger issue dropped, older issue captured
    do_reset();
    IN_req = 2'b01;
    IN_reqSqN = {7'd0, 7'd30};
    tick();
    IN_req = 2'b00;
    IN_issue = 2'b01;
    IN_issueSqN = {7'd0, 7'd30};
    IN_branchTaken = 1'b1;
    IN_branchSqN = 7'd20;
    tick();
    clear_in();
    chk("gflush_drop_busy", OUT_busy, 1'b0);
    IN_req = 2'b01;
    IN_reqSqN = {7'd0, 7'd30};
    tick();
    chk("gflush_regrant", OUT_doNotIssueDiv, 2'b10);
    IN_req = 2'b00;
    IN_issue = 2'b01;
    IN_issueSqN = {7'd0, 7'd30};
    IN_branchTaken = 1'b1;
    IN_branchSqN = 7'd40;
    tick();
    clear_in();
    chk("gflush_keep_busy", OUT_busy, 1'b1);

    // reset mid-division aborts without pulses
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mid_rst_busy", OUT_busy, 1'b0);
    seen = 0;
    for (int k = 0; k < 40; k++) begin
      if (OUT_wbReserve || OUT_done) seen++;
      tick();
    end
    chk("mid_rst_no_pulse", seen, 0);

    // back-to-back with both ports always requesting
    do_reset();
    IN_req = 2'b11;
    IN_reqSqN = {7'd41, 7'd40};
    last = -1;
    n_iss = 0;
    two_low = 0;
    for (int c = 0; c < 120; c++) begin
      tick();
      IN_issue = 2'b00;
      if ($countones(~OUT_doNotIssueDiv) > 1) two_low++;
      for (int p = 0; p < 2; p++) begin
        if (!OUT_doNotIssueDiv[p]) begin
          IN_issue[p] = 1'b1;
          IN_issueSqN = IN_reqSqN;
          IN_issueTag = {7'(n_iss), 7'(n_iss)};
          if (last >= 0) chk("b2b_gap", cyc - last, 34);
          last = cyc;
          n_iss++;
        end
      end
    end
    clear_in();
    chk("b2b_two_low", two_low, 0);
    chk("b2b_count", n_iss, 4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
